bit_field_packer: RTL and testbench

- Write-side counterpart of the variable part-select read: inserts variable-width fields at a running bit offset, i.e. ACC[POS +: LEN] = field.
- Packs them LSB-first into WORD_W-bit words.
- Completed words leave through a registered valid/ready output.
- A flush request emits a partially filled word.
- Sits between a field producer (header/bitstream builder) and a word-wide sink.

---
 rtl/bit_field_packer_if.sv | 28 ++
 rtl/bit_field_packer.sv | 97 +++++++++
 tb/tb_bit_field_packer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bit_field_packer_if.sv
// Field-in / word-out handshake bundle for bit_field_packer.
// The slave modport is the packer's view; the master modport is the producer/sink view.
interface bit_field_packer_if #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned MAXF_W = 8,
    parameter int unsigned LEN_W  = $clog2(MAXF_W + 1),
    parameter int unsigned POS_W  = $clog2(WORD_W)
);
    logic [MAXF_W-1:0] IN_DATA;
    logic [LEN_W-1:0]  IN_LEN;
    logic              IN_VALID;
    logic              IN_READY;
    logic              FLUSH;
    logic [WORD_W-1:0] OUT_DATA;
    logic [POS_W:0]    OUT_FILL;
    logic              OUT_VALID;
    logic              OUT_READY;

    modport slave (
        input  IN_DATA, IN_LEN, IN_VALID, FLUSH, OUT_READY,
        output IN_READY, OUT_DATA, OUT_FILL, OUT_VALID
    );

    modport master (
        output IN_DATA, IN_LEN, IN_VALID, FLUSH, OUT_READY,
        input  IN_READY, OUT_DATA, OUT_FILL, OUT_VALID
    );
endinterface

// File: rtl/bit_field_packer.sv
// Packs variable-width fields LSB-first into WORD_W-bit words (ACC[POS +: LEN] = field),
// with a registered valid/ready word output and a flush for partially filled words.
module bit_field_packer #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned MAXF_W = 8,
    parameter int unsigned LEN_W  = $clog2(MAXF_W + 1),
    parameter int unsigned POS_W  = $clog2(WORD_W)
) (
    input logic              CLK,
    input logic              RST,
    bit_field_packer_if.slave bus
);
    typedef enum logic {StFilling, StPending} state_e;

    localparam logic [POS_W:0]   FullFill = (POS_W + 1)'(WORD_W);
    localparam logic [LEN_W-1:0] MaxLen   = LEN_W'(MAXF_W);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic [POS_W:0]    out_fill_q, out_fill_d;

    logic [LEN_W-1:0]    len_l;
    logic [MAXF_W-1:0]   field_m;
    logic [POS_W:0]      sum;
    logic [2*WORD_W-1:0] ins;
    logic                in_ready;
    logic                take_field;
    logic                take_flush;

    assign in_ready      = (state_q == StFilling) || bus.OUT_READY;
    assign bus.IN_READY  = in_ready;
    assign bus.OUT_DATA  = out_data_q;
    assign bus.OUT_FILL  = out_fill_q;
    assign bus.OUT_VALID = (state_q == StPending);

    always_comb begin
        len_l = (bus.IN_LEN > MaxLen) ? MaxLen : bus.IN_LEN;
        field_m = '0;
        for (int i = 0; i < int'(MAXF_W); i++) begin
            field_m[i] = bus.IN_DATA[i] & (i < int'(len_l));
        end
        sum = {1'b0, pos_q} + (POS_W + 1)'(len_l);
        // Upper half of the shifted field is the carry into the next word; ACC bits at and
        // above POS are always zero, so OR-ing inserts the field.
        ins = (2 * WORD_W)'(field_m) << pos_q;

        take_field = bus.IN_VALID && in_ready;
        take_flush = bus.FLUSH && !bus.IN_VALID && in_ready;

        state_d    = state_q;
        acc_d      = acc_q;
        pos_d      = pos_q;
        out_data_d = out_data_q;
        out_fill_d = out_fill_q;

        if (bus.OUT_READY) begin
            state_d = StFilling;
        end

        if (take_field) begin
            if (sum >= FullFill) begin
                out_data_d = acc_q | ins[WORD_W-1:0];
                out_fill_d = FullFill;
                state_d    = StPending;
                acc_d      = ins[2*WORD_W-1:WORD_W];
                pos_d      = POS_W'(sum - FullFill);
            end else begin
                acc_d = acc_q | ins[WORD_W-1:0];
                pos_d = sum[POS_W-1:0];
            end
        end else if (take_flush && (pos_q != '0)) begin
            out_data_d = acc_q;
            out_fill_d = {1'b0, pos_q};
            state_d    = StPending;
            acc_d      = '0;
            pos_d      = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StFilling;
            acc_q      <= '0;
            pos_q      <= '0;
            out_data_q <= '0;
            out_fill_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            pos_q      <= pos_d;
            out_data_q <= out_data_d;
            out_fill_q <= out_fill_d;
        end
    end
endmodule

// File: tb/tb_bit_field_packer.sv
// Directed and random bench for bit_field_packer: a bit-serial reference model feeds a word
// scoreboard that is checked whenever the packer hands a word to the sink.
module tb_bit_field_packer;
    typedef struct {
        logic [31:0] d;
        logic [5:0]  f;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   errors = 0;
    int   checks = 0;

    exp_t sb[$];
    bit   mbits[$];

    bit_field_packer_if #(.WORD_W(32), .MAXF_W(8), .LEN_W(4), .POS_W(5)) bus ();

    bit_field_packer #(.WORD_W(32), .MAXF_W(8), .LEN_W(4), .POS_W(5)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_field(input logic [7:0] d, input logic [3:0] len);
        int l;
        logic [31:0] w;
        l = (len > 4'd8) ? 8 : int'(len);
        for (int i = 0; i < l; i++) mbits.push_back(d[i]);
        while (mbits.size() >= 32) begin
            w = '0;
            for (int i = 0; i < 32; i++) w[i] = mbits.pop_front();
            sb.push_back('{w, 6'd32});
        end
    endtask

    task automatic model_flush();
        int n;
        logic [31:0] w;
        n = mbits.size();
        if (n > 0) begin
            w = '0;
            for (int i = 0; i < n; i++) w[i] = mbits.pop_front();
            sb.push_back('{w, 6'(n)});
        end
    endtask

    // One clock: words handed over at this edge are popped and compared at the negedge.
    task automatic tick();
        exp_t e;
        @(negedge CLK);
        if (bus.OUT_VALID && bus.OUT_READY) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", 64'(bus.OUT_DATA), 64'hDEAD_0000_0000);
            end else begin
                e = sb.pop_front();
                chk("sb_data", 64'(bus.OUT_DATA), 64'(e.d));
                chk("sb_fill", 64'(bus.OUT_FILL), 64'(e.f));
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        #1;
        while (!bus.IN_READY && n < 50) begin
            bus.OUT_READY = 1'b1;
            #1;
            n++;
        end
        if (!bus.IN_READY) chk(tag, 64'(bus.IN_READY), 64'd1);
    endtask

    task automatic send_field(input logic [7:0] d, input logic [3:0] len);
        bus.IN_DATA  = d;
        bus.IN_LEN   = len;
        bus.IN_VALID = 1'b1;
        wait_ready("field_ready_timeout");
        model_field(d, len);
        tick();
        bus.IN_VALID = 1'b0;
    endtask

    task automatic send_flush();
        bus.IN_VALID = 1'b0;
        bus.FLUSH    = 1'b1;
        wait_ready("flush_ready_timeout");
        model_flush();
        tick();
        bus.FLUSH = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        sb.delete();
        mbits.delete();
    endtask

    initial begin
        bus.IN_DATA   = '0;
        bus.IN_LEN    = '0;
        bus.IN_VALID  = 1'b0;
        bus.FLUSH     = 1'b0;
        bus.OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        do_reset();

        // Reset state
        chk("rst_valid", 64'(bus.OUT_VALID), 64'd0);
        chk("rst_data", 64'(bus.OUT_DATA), 64'd0);
        chk("rst_fill", 64'(bus.OUT_FILL), 64'd0);
        chk("rst_in_ready", 64'(bus.IN_READY), 64'd1);

        // Four byte fields make one full word
        send_field(8'h11, 4'd8);
        send_field(8'h22, 4'd8);
        send_field(8'h33, 4'd8);
        send_field(8'h44, 4'd8);
        chk("t1_valid", 64'(bus.OUT_VALID), 64'd1);
        chk("t1_data", 64'(bus.OUT_DATA), 64'h4433_2211);
        chk("t1_fill", 64'(bus.OUT_FILL), 64'd32);
        tick();
        chk("t1_valid_one_cycle", 64'(bus.OUT_VALID), 64'd0);
        send_flush();
        chk("t1_pos_zero", 64'(bus.OUT_VALID), 64'd0);

        // Straddling field
        send_field(8'h00, 4'd8);
        send_field(8'h00, 4'd8);
        send_field(8'h00, 4'd8);
        send_field(8'h00, 4'd6);
        send_field(8'h0F, 4'd4);
        chk("t2_word_data", 64'(bus.OUT_DATA), 64'hC000_0000);
        chk("t2_word_fill", 64'(bus.OUT_FILL), 64'd32);
        send_flush();
        chk("t2_flush_data", 64'(bus.OUT_DATA), 64'h0000_0003);
        chk("t2_flush_fill", 64'(bus.OUT_FILL), 64'd2);
        tick();

        // Backpressure
        bus.OUT_READY = 1'b0;
        send_field(8'h01, 4'd8);
        send_field(8'h02, 4'd8);
        send_field(8'h03, 4'd8);
        send_field(8'h04, 4'd8);
        bus.IN_DATA  = 8'h55;
        bus.IN_LEN   = 4'd8;
        bus.IN_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_in_ready_low", 64'(bus.IN_READY), 64'd0);
            tick();
            chk("t3_hold_data", 64'(bus.OUT_DATA), 64'h0403_0201);
            chk("t3_hold_valid", 64'(bus.OUT_VALID), 64'd1);
        end
        bus.OUT_READY = 1'b1;
        #1;
        chk("t3_in_ready_release", 64'(bus.IN_READY), 64'd1);
        model_field(8'h55, 4'd8);
        tick();
        bus.IN_VALID = 1'b0;
        send_flush();
        chk("t3_flush_data", 64'(bus.OUT_DATA), 64'h0000_0055);
        chk("t3_flush_fill", 64'(bus.OUT_FILL), 64'd8);
        tick();

        // Flush cases
        send_flush();
        chk("t4_flush_empty", 64'(bus.OUT_VALID), 64'd0);
        send_field(8'h15, 4'd5);
        send_flush();
        chk("t4_flush_data", 64'(bus.OUT_DATA), 64'h0000_0015);
        chk("t4_flush_fill", 64'(bus.OUT_FILL), 64'd5);
        tick();
        send_field(8'h01, 4'd1);
        bus.IN_DATA  = 8'h02;
        bus.IN_LEN   = 4'd2;
        bus.IN_VALID = 1'b1;
        bus.FLUSH    = 1'b1;
        #1;
        model_field(8'h02, 4'd2);
        tick();
        bus.IN_VALID = 1'b0;
        #1;
        chk("t4_flush_deferred", 64'(bus.OUT_VALID), 64'd0);
        model_flush();
        tick();
        bus.FLUSH = 1'b0;
        chk("t4_prio_data", 64'(bus.OUT_DATA), 64'h0000_0005);
        chk("t4_prio_fill", 64'(bus.OUT_FILL), 64'd3);
        tick();

        // Masking and clamping
        send_field(8'hFF, 4'd3);
        send_field(8'hAB, 4'd0);
        send_field(8'hFF, 4'd12);
        send_flush();
        chk("t5_data", 64'(bus.OUT_DATA), 64'h0000_07FF);
        chk("t5_fill", 64'(bus.OUT_FILL), 64'd11);
        tick();

        // Reset mid-word
        send_field(8'hFF, 4'd8);
        send_field(8'hFF, 4'd8);
        send_field(8'h0F, 4'd4);
        do_reset();
        chk("t6_valid", 64'(bus.OUT_VALID), 64'd0);
        send_flush();
        chk("t6_pos_zero", 64'(bus.OUT_VALID), 64'd0);
        for (int i = 0; i < 4; i++) send_field(8'hA5, 4'd8);
        chk("t6_data", 64'(bus.OUT_DATA), 64'hA5A5_A5A5);
        chk("t6_fill", 64'(bus.OUT_FILL), 64'd32);
        tick();

        // Random fields, flushes and sink stalls against the bit-serial model
        for (int i = 0; i < 300; i++) begin
            bus.OUT_READY = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) send_flush();
            else send_field(8'($urandom), 4'($urandom_range(0, 15)));
        end
        bus.OUT_READY = 1'b1;
        send_flush();
        for (int i = 0; i < 4; i++) tick();
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
